// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM encoding, keyboard command bytes and default timing values.
package ps2_pkg;

  typedef logic [2:0] ps2_state_t;

  localparam ps2_state_t StIdle     = 3'd0;
  localparam ps2_state_t StInhibit  = 3'd1;
  localparam ps2_state_t StReq      = 3'd2;
  localparam ps2_state_t StData     = 3'd3;
  localparam ps2_state_t StParity   = 3'd4;
  localparam ps2_state_t StStop     = 3'd5;
  localparam ps2_state_t StAck      = 3'd6;
  localparam ps2_state_t StWaitIdle = 3'd7;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LED  = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_ACK_RESP = 8'hFA;

  localparam int unsigned DefInhibitCycles = 12000;
  localparam int unsigned DefTimeoutCycles = 2000000;
  localparam int unsigned DefFilterLen     = 8;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_edge_filter.sv
// PS/2 clock conditioning: 2-flop synchroniser, run-length glitch filter and falling-edge pulse.
module ps2_edge_filter import ps2_pkg::*; #(
  parameter int unsigned FILTER_LEN = DefFilterLen
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw_i,
  output logic filt_o,
  output logic fall_o
);

  localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

  logic [1:0]      sync_q;
  logic            filt_q, filt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fall_q;

  // Filter output only follows after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CntW'(FILTER_LEN - 1)) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      fall_q <= filt_q & ~filt_d;
    end
  end

  assign filt_o = filt_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain clock/data enables.
// Define PS2_HOST_TX_RETRY_EN to retry a NACKed byte once before reporting.
module ps2_host_tx import ps2_pkg::*; #(
  parameter int unsigned INHIBIT_CYCLES = DefInhibitCycles,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter int unsigned FILTER_LEN     = DefFilterLen
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout
);

  localparam int unsigned CntMax = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES
                                                                     : INHIBIT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  logic            clk_filt, fall;
  logic [1:0]      data_sync_q;
  logic            data_sync;

  ps2_state_t      state_q, state_d;
  logic [7:0]      byte_q, byte_d;
  logic            par_q, par_d;
  logic [2:0]      bit_q, bit_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            clk_oe_q, clk_oe_d;
  logic            data_oe_q, data_oe_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            ready_q, ready_d;
  logic            timed, enter_inhibit;
`ifdef PS2_HOST_TX_RETRY_EN
  logic            retried_q, retried_d;
`endif

  ps2_edge_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk    (clk),
    .rstn   (rstn),
    .raw_i  (ps2_clk_in),
    .filt_o (clk_filt),
    .fall_o (fall)
  );

  assign data_sync = data_sync_q[1];

  always_comb begin
    state_d       = state_q;
    byte_d        = byte_q;
    par_d         = par_q;
    bit_d         = bit_q;
    cnt_d         = cnt_q;
    clk_oe_d      = clk_oe_q;
    data_oe_d     = data_oe_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    ack_d         = 1'b0;
    err_d         = 1'b0;
    enter_inhibit = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
    retried_d     = retried_q;
`endif

    // The device owns the clock from REQ onward; any silent gap counts towards the timeout.
    timed = (state_q != StIdle) && (state_q != StInhibit);
    if (timed) begin
      cnt_d = fall ? '0 : cnt_q + CntW'(1);
    end

    case (state_q)
      StIdle: begin
        if (tx_valid && ready_q) begin
          byte_d        = tx_data;
          par_d         = odd_parity(tx_data);
          busy_d        = 1'b1;
          enter_inhibit = 1'b1;
`ifdef PS2_HOST_TX_RETRY_EN
          retried_d     = 1'b0;
`endif
        end
      end
      StInhibit: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(INHIBIT_CYCLES - 1)) begin
          clk_oe_d = 1'b0;
          cnt_d    = '0;
          state_d  = StReq;
        end else if (cnt_q == CntW'(INHIBIT_CYCLES - 2)) begin
          data_oe_d = 1'b1;
        end
      end
      StReq: begin
        bit_d   = 3'd0;
        state_d = StData;
      end
      StData: begin
        if (fall) begin
          data_oe_d = ~byte_q[bit_q];
          if (bit_q == 3'd7) begin
            state_d = StParity;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (fall) begin
          data_oe_d = ~par_q;
          state_d   = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          data_oe_d = 1'b0;
          state_d   = StAck;
        end
      end
      StAck: begin
        if (fall) begin
          if (!data_sync) begin
            state_d = StWaitIdle;
          end else begin
`ifdef PS2_HOST_TX_RETRY_EN
            if (!retried_q) begin
              retried_d     = 1'b1;
              enter_inhibit = 1'b1;
            end else begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = StIdle;
            end
`else
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
`endif
          end
        end
      end
      StWaitIdle: begin
        if (clk_filt && data_sync) begin
          done_d  = 1'b1;
          ack_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (enter_inhibit) begin
      state_d   = StInhibit;
      cnt_d     = '0;
      bit_d     = 3'd0;
      clk_oe_d  = 1'b1;
      data_oe_d = (INHIBIT_CYCLES == 1);
    end

    if (timed && !fall && (cnt_q == CntW'(TIMEOUT_CYCLES - 1))) begin
      state_d   = StIdle;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      ack_d     = 1'b0;
      err_d     = 1'b1;
    end

    // Held low through the done cycle so a new byte is never accepted alongside the report.
    ready_d = (state_d == StIdle) && !done_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_sync_q <= 2'b11;
      state_q     <= StIdle;
      byte_q      <= '0;
      par_q       <= 1'b0;
      bit_q       <= '0;
      cnt_q       <= '0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      retried_q   <= 1'b0;
`endif
    end else begin
      data_sync_q <= {data_sync_q[0], ps2_data_in};
      state_q     <= state_d;
      byte_q      <= byte_d;
      par_q       <= par_d;
      bit_q       <= bit_d;
      cnt_q       <= cnt_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
`ifdef PS2_HOST_TX_RETRY_EN
      retried_q   <= retried_d;
`endif
    end
  end

  assign tx_ready    = ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_ok      = ack_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on the open-drain lines.
module tb_ps2_host_tx;

  localparam int unsigned Inh  = 20;
  localparam int unsigned To   = 3000;
  localparam int unsigned Flt  = 8;
  localparam int          Half = 40;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, err_timeout;
  logic       ps2_clk_in, ps2_data_in;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (Inh),
    .TIMEOUT_CYCLES (To),
    .FILTER_LEN     (Flt)
  ) u_dut (
    .clk         (clk),
    .rstn        (rstn),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .ack_ok      (ack_ok),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc_cnt = 0, done_cnt = 0, inh_cnt = 0, inh_run = 0, inh_len = 0;
  int unsigned t_done = 0, t_fall = 0;
  logic        last_ack = 1'b0, last_err = 1'b0, prev_oe = 1'b0;

  always @(negedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    prev_oe <= ps2_clk_oe;
    if (done) begin
      done_cnt <= done_cnt + 1;
      last_ack <= ack_ok;
      last_err <= err_timeout;
      t_done   <= cyc_cnt;
    end
    if (ps2_clk_oe && !prev_oe) inh_cnt <= inh_cnt + 1;
    if (ps2_clk_oe) begin
      inh_run <= inh_run + 1;
    end else if (inh_run != 0) begin
      inh_len <= inh_run;
      inh_run <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int k = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && k < 100) begin
      cyc(1);
      k++;
    end
    if (!tx_ready) begin
      check("accept_wait", 32'd0, 32'd1);
      tx_valid = 1'b0;
      return;
    end
    cyc(1);
    tx_valid = 1'b0;
    check("busy_on_accept", busy, 1);
    check("clk_oe_on_accept", ps2_clk_oe, 1);
  endtask

  task automatic dev_pulse(output logic s);
    dev_clk_low = 1'b1;
    cyc(Half);
    s = ps2_data_in;
    dev_clk_low = 1'b0;
    cyc(Half);
  endtask

  task automatic wait_req();
    int k = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && k < 2000) begin
      cyc(1);
      k++;
    end
    if (k >= 2000) check("req_wait", 32'd0, 32'd1);
  endtask

  // Device side of one frame: npulse clocks, sampling before each rising edge.
  task automatic dev_xfer(input logic do_ack, input int npulse, input bit glitch,
                          output logic start, output logic [7:0] b, output logic par,
                          output logic stopb);
    logic s;
    b = 8'h00;
    par = 1'b0;
    stopb = 1'b0;
    wait_req();
    start = ps2_data_in;
    cyc(Half);
    for (int i = 0; i < npulse; i++) begin
      if (i == 10) dev_data_low = do_ack;
      t_fall = cyc_cnt;
      dev_pulse(s);
      if (i < 8) b[i] = s;
      else if (i == 8) par = s;
      else if (i == 9) stopb = s;
      if (i == 10) dev_data_low = 1'b0;
      if (glitch && i == 3) begin
        dev_clk_low = 1'b1;
        cyc(3);
        dev_clk_low = 1'b0;
        cyc(Half);
      end
    end
  endtask

  task automatic wait_done(input int unsigned base, input int budget);
    int k = 0;
    while (done_cnt == base && k < budget) begin
      cyc(1);
      k++;
    end
    if (done_cnt == base) check("done_wait", 32'd0, 32'd1);
  endtask

  task automatic full_xfer(input string tag, input logic [7:0] b, input logic exp_par,
                           input bit glitch);
    int unsigned base;
    logic st, p, sp;
    logic [7:0] got;
    base = done_cnt;
    send(b);
    dev_xfer(1'b1, 11, glitch, st, got, p, sp);
    wait_done(base, 500);
    cyc(2);
    check({tag, "_start"}, st, 0);
    check({tag, "_byte"}, got, b);
    check({tag, "_parity"}, p, exp_par);
    check({tag, "_stop"}, sp, 1);
    check({tag, "_done_cnt"}, done_cnt - base, 1);
    check({tag, "_ack"}, last_ack, 1);
    check({tag, "_err"}, last_err, 0);
    check({tag, "_idle_oes"}, {ps2_clk_oe, ps2_data_oe, busy}, 0);
  endtask

  initial begin
    int unsigned base, i0;
    logic st, p, sp, s;
    logic [7:0] got;

    cyc(3);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_flags", {busy, done, ack_ok, err_timeout}, 0);
    check("rst_ready", tx_ready, 0);
    #2 rstn = 1'b1;
    cyc(1);
    check("ready_after_rst", tx_ready, 1);

    full_xfer("ed", 8'hED, 1'b1, 1'b0);
    check("inhibit_len", inh_len, Inh);
    full_xfer("ff_glitch", 8'hFF, 1'b1, 1'b1);
    full_xfer("zero", 8'h00, 1'b1, 1'b0);

    // Device goes silent after four clocks.
    base = done_cnt;
    send(8'hA5);
    dev_xfer(1'b1, 4, 1'b0, st, got, p, sp);
    wait_done(base, To + 200);
    cyc(2);
    check("to_err", last_err, 1);
    check("to_ack", last_ack, 0);
    check("to_oes", {ps2_clk_oe, ps2_data_oe, busy}, 0);
    check("to_gap_ok", ((t_done - t_fall) >= To) && ((t_done - t_fall) <= To + 40), 1);
    check("to_bits", got[3:0], 4'h5);

    // NACK of 0xF4.
    base = done_cnt;
    i0 = inh_cnt;
    send(8'hF4);
    dev_xfer(1'b0, 11, 1'b0, st, got, p, sp);
    check("nack_byte", got, 8'hF4);
    check("nack_parity", p, 0);
`ifdef PS2_HOST_TX_RETRY_EN
    check("nack_no_done_yet", done_cnt - base, 0);
    dev_xfer(1'b1, 11, 1'b0, st, got, p, sp);
    wait_done(base, 500);
    cyc(Half * 4);
    check("retry_byte", got, 8'hF4);
    check("retry_inhibits", inh_cnt - i0, 2);
    check("retry_done_cnt", done_cnt - base, 1);
    check("retry_ack", last_ack, 1);
    check("retry_err", last_err, 0);
`else
    wait_done(base, 500);
    cyc(Half * 4);
    check("nack_inhibits", inh_cnt - i0, 1);
    check("nack_done_cnt", done_cnt - base, 1);
    check("nack_ack", last_ack, 0);
    check("nack_err", last_err, 0);
`endif

    // Reset in the middle of the data bits.
    send(8'hF4);
    wait_req();
    cyc(Half);
    dev_pulse(s);
    dev_pulse(s);
    check("pre_rst_data_oe", ps2_data_oe, 1);
    #3 rstn = 1'b0;
    #1;
    check("mid_rst_oes", {ps2_clk_oe, ps2_data_oe}, 0);
    check("mid_rst_busy", busy, 0);
    cyc(2);
    #2 rstn = 1'b1;
    cyc(1);
    check("ready_after_mid_rst", tx_ready, 1);
    full_xfer("f4_after_rst", 8'hF4, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
